mac_lookup_ctrl: RTL and testbench

// - Initiator side of the MAC table: parses each ingress frame header byte stream, extracts DA and SA,

---
 rtl/mac_lookup_ctrl_pkg.sv | 26 ++
 rtl/mac_lookup_ctrl_if.sv | 29 ++
 rtl/mac_lookup_ctrl_hash.sv | 50 +++++
 rtl/mac_lookup_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mac_lookup_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_lookup_ctrl_pkg.sv
// Shared definitions for the MAC table lookup controller: default widths,
// header length, parser state encoding and the forwarding decision record.
package mac_pkg;

   localparam int PORT_NUM  = 4;
   localparam int SLOTS     = 256;
   localparam int PW        = $clog2(PORT_NUM);
   localparam int IW        = $clog2(SLOTS);
   localparam int MAC_BYTES = 6;

   typedef enum logic [2:0] {
      IDLE,
      DA,
      SA,
      LOOKUP,
      WAIT,
      RESULT
   } state_t;

   typedef struct packed {
      logic [PW-1:0] port;
      logic          flood;
      logic          drop;
   } fwd_t;

endpackage

// File: rtl/mac_lookup_ctrl_if.sv
// Forwarding decision channel between the lookup controller (master)
// and the switch fabric (slave); valid/ready handshake.
interface mac_lookup_ctrl_if #(
   parameter int pPW = 2
);

   logic           o_fwd_valid;
   logic           i_fwd_ready;
   logic [pPW-1:0] o_fwd_port;
   logic           o_fwd_flood;
   logic           o_fwd_drop;

   modport master (
      output o_fwd_valid,
      output o_fwd_port,
      output o_fwd_flood,
      output o_fwd_drop,
      input  i_fwd_ready
   );

   modport slave (
      input  o_fwd_valid,
      input  o_fwd_port,
      input  o_fwd_flood,
      input  o_fwd_drop,
      output i_fwd_ready
   );

endinterface

// File: rtl/mac_lookup_ctrl_hash.sv
// MAC address to table slot index hash (combinational).
// Algorithm is chosen by the MAC_LOOKUP_CRC_HASH_EN macro:
//   defined   : CRC-8, poly 0x07, init 0x00, MSB-first, low pIW bits
//   undefined : XOR fold of the address in pIW-bit chunks from the LSB
// The MAC table itself is address-agnostic, so every controller feeding
// the same table must be built with the same setting.
module mac_hash #(
   parameter int pMAC_W = 48,
   parameter int pIW    = 8
) (
   input  logic [pMAC_W-1:0] i_mac,
   output logic [pIW-1:0]    o_idx
);

`ifdef MAC_LOOKUP_CRC_HASH_EN

   if (pIW > 8) begin : g_iw_chk
      $error("mac_hash: CRC-8 hash supports at most 256 slots");
   end

   logic [7:0] w_crc;

   // Bit-serial CRC-8 over the whole address, most significant bit first
   always_comb begin
      w_crc = 8'h00;
      for (int b = pMAC_W - 1; b >= 0; b--) begin
         if (w_crc[7] ^ i_mac[b]) begin
            w_crc = {w_crc[6:0], 1'b0} ^ 8'h07;
         end else begin
            w_crc = {w_crc[6:0], 1'b0};
         end
      end
      o_idx = w_crc[pIW-1:0];
   end

`else

   localparam int lCHUNKS = (pMAC_W + pIW - 1) / pIW;

   // XOR fold; the top chunk is implicitly zero-padded by the shift
   always_comb begin
      o_idx = '0;
      for (int c = 0; c < lCHUNKS; c++) begin
         o_idx = o_idx ^ pIW'(i_mac >> (c * pIW));
      end
   end

`endif

endmodule

// File: rtl/mac_lookup_ctrl.sv
// MAC table initiator: parses DA/SA from the ingress header byte stream,
// issues a learn write (SA -> ingress port) and a DA lookup to the table,
// then returns one forwarding decision per frame over a valid/ready channel.
// Hash algorithm selected by MAC_LOOKUP_CRC_HASH_EN (see mac_hash).
module mac_lookup_ctrl
   import mac_pkg::*;
#(
   parameter int pPORT_NUM = 4,
   parameter int pSLOTS    = 256,
   parameter int pMAC_W    = 48
) (
   input  logic                         iclk,
   input  logic                         irst,
   input  logic [7:0]                   i_data,
   input  logic                         i_valid,
   input  logic                         i_sof,
   input  logic [$clog2(pPORT_NUM)-1:0] i_src_port,
   output logic                         o_ready,
   output logic                         o_write_enable,
   output logic [$clog2(pPORT_NUM)-1:0] o_port_num,
   output logic [$clog2(pSLOTS)-1:0]    o_MAC_SA,
   output logic [$clog2(pSLOTS)-1:0]    o_MAC_DA,
   input  logic [$clog2(pPORT_NUM)-1:0] i_port_num,
   mac_lookup_ctrl_if.master            fwd
);

   localparam int lPW = $clog2(pPORT_NUM);
   localparam int lIW = $clog2(pSLOTS);

   // The decision record in the package is sized for the default port count
   if (lPW != PW) begin : g_pw_chk
      $error("mac_lookup_ctrl: pPORT_NUM must give the package port width");
   end
   if (pMAC_W != MAC_BYTES * 8) begin : g_mac_chk
      $error("mac_lookup_ctrl: pMAC_W must equal MAC_BYTES*8");
   end

   // Control / table-facing registers
   state_t           r_state;
   logic [2:0]       r_cnt;
   logic             r_ready;
   logic             r_we;
   logic [lPW-1:0]   r_port_num;
   logic [lIW-1:0]   r_mac_sa;
   logic [lIW-1:0]   r_mac_da;
   logic             r_fwd_valid;
   fwd_t             r_fwd;

   // Header datapath registers (no reset needed: fully overwritten per frame)
   logic [pMAC_W-1:0] r_da;
   logic [pMAC_W-1:0] r_sa;
   logic [lPW-1:0]    r_src;

   logic              w_acc;
   logic              w_start;
   logic              w_da_shift;
   logic              w_sa_shift;
   logic              w_last;
   logic              w_sa_mcast;
   logic              w_da_mcast;
   logic [pMAC_W-1:0] w_sa_next;
   logic [lIW-1:0]    w_da_idx;
   logic [lIW-1:0]    w_sa_idx;

   assign w_acc      = i_valid & r_ready;
   assign w_start    = w_acc & i_sof;
   assign w_da_shift = w_acc & ~i_sof & (r_state == DA);
   assign w_sa_shift = w_acc & ~i_sof & (r_state == SA);
   assign w_last     = (r_cnt == 3'(MAC_BYTES - 1));

   // SA including the byte being accepted now, so LOOKUP outputs can be
   // registered on the same edge that takes the 6th SA byte
   assign w_sa_next  = {r_sa[pMAC_W-9:0], i_data};

   // Group bit is bit0 of address byte0, i.e. the LSB of the top byte
   assign w_sa_mcast = w_sa_next[pMAC_W-8];
   assign w_da_mcast = r_da[pMAC_W-8];

   mac_hash #(
      .pMAC_W (pMAC_W),
      .pIW    (lIW)
   ) u_hash_da (
      .i_mac  (r_da),
      .o_idx  (w_da_idx)
   );

   mac_hash #(
      .pMAC_W (pMAC_W),
      .pIW    (lIW)
   ) u_hash_sa (
      .i_mac  (w_sa_next),
      .o_idx  (w_sa_idx)
   );

   // Header shift registers and ingress port capture on the sof byte
   always_ff @(posedge iclk) begin
      if (w_start | w_da_shift) begin
         r_da <= {r_da[pMAC_W-9:0], i_data};
      end
      if (w_sa_shift) begin
         r_sa <= w_sa_next;
      end
      if (w_start) begin
         r_src <= i_src_port;
      end
   end

   // Parser / lookup FSM with registered table and decision outputs
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_state     <= IDLE;
         r_cnt       <= 3'd0;
         r_ready     <= 1'b1;
         r_we        <= 1'b0;
         r_port_num  <= '0;
         r_mac_sa    <= '0;
         r_mac_da    <= '0;
         r_fwd_valid <= 1'b0;
         r_fwd       <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            IDLE: begin
               // Non-sof bytes here are payload/FCS and are simply dropped
               if (w_start) begin
                  r_state <= DA;
                  r_cnt   <= 3'd1;
               end
            end
            DA: begin
               if (w_start) begin
                  r_cnt <= 3'd1;
               end else if (w_da_shift) begin
                  if (w_last) begin
                     r_state <= SA;
                     r_cnt   <= 3'd0;
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end
            SA: begin
               if (w_start) begin
                  // New frame before header complete: abandon, no table access
                  r_state <= DA;
                  r_cnt   <= 3'd1;
               end else if (w_sa_shift) begin
                  if (w_last) begin
                     r_state  <= LOOKUP;
                     r_cnt    <= 3'd0;
                     r_ready  <= 1'b0;
                     r_mac_da <= w_da_idx;
                     // Group source addresses are never learned
                     r_we     <= ~w_sa_mcast;
                     if (!w_sa_mcast) begin
                        r_mac_sa   <= w_sa_idx;
                        r_port_num <= r_src;
                     end
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end
            LOOKUP: begin
               r_state <= WAIT;
            end
            WAIT: begin
               // Table read data is valid this cycle
               r_fwd_valid <= 1'b1;
               r_fwd.port  <= i_port_num;
               r_fwd.flood <= w_da_mcast;
               r_fwd.drop  <= ~w_da_mcast & (i_port_num == r_src);
               r_state     <= RESULT;
            end
            RESULT: begin
               if (fwd.i_fwd_ready) begin
                  r_fwd_valid <= 1'b0;
                  r_ready     <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready         = r_ready;
   assign o_write_enable  = r_we;
   assign o_port_num      = r_port_num;
   assign o_MAC_SA        = r_mac_sa;
   assign o_MAC_DA        = r_mac_da;

   assign fwd.o_fwd_valid = r_fwd_valid;
   assign fwd.o_fwd_port  = r_fwd.port;
   assign fwd.o_fwd_flood = r_fwd.flood;
   assign fwd.o_fwd_drop  = r_fwd.drop;

endmodule

// File: tb/tb_mac_lookup_ctrl.sv
// Testbench for mac_lookup_ctrl: table-driven frame vectors with a
// behavioural MAC table (registered read, read-before-write), plus
// hand-written abort, back-pressure and mid-frame reset sequences.
// Build with MAC_LOOKUP_CRC_HASH_EN to check the CRC-8 index variant.
module tb_mac_lookup_ctrl;

   typedef struct {
      logic [1:0]  src;
      logic [47:0] da;
      logic [47:0] sa;
      logic        exp_we;
      logic [7:0]  exp_sa_idx;
      logic [7:0]  exp_da_idx;
      logic [1:0]  exp_pnum;
      logic        exp_flood;
      logic        exp_drop;
      logic [1:0]  exp_port;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] i_data;
   logic       i_valid;
   logic       i_sof;
   logic [1:0] i_src_port;
   logic       o_ready;
   logic       o_write_enable;
   logic [1:0] o_port_num;
   logic [7:0] o_MAC_SA;
   logic [7:0] o_MAC_DA;
   logic [1:0] i_port_num;

   int n_chk  = 0;
   int n_fail = 0;

   mac_lookup_ctrl_if #(.pPW(2)) fwd_if ();

   mac_lookup_ctrl #(
      .pPORT_NUM (4),
      .pSLOTS    (256),
      .pMAC_W    (48)
   ) dut (
      .iclk           (clk),
      .irst           (rst),
      .i_data         (i_data),
      .i_valid        (i_valid),
      .i_sof          (i_sof),
      .i_src_port     (i_src_port),
      .o_ready        (o_ready),
      .o_write_enable (o_write_enable),
      .o_port_num     (o_port_num),
      .o_MAC_SA       (o_MAC_SA),
      .o_MAC_DA       (o_MAC_DA),
      .i_port_num     (i_port_num),
      .fwd            (fwd_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural MAC table: 1-cycle registered read, same-slot read sees old data
   logic [1:0] tbl_mem [256] = '{default: 2'd0};
   logic [1:0] tbl_q = 2'd0;
   always @(posedge clk) begin
      if (o_write_enable) tbl_mem[o_MAC_SA] <= o_port_num;
      tbl_q <= tbl_mem[o_MAC_DA];
   end
   assign i_port_num = tbl_q;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

`ifdef MAC_LOOKUP_CRC_HASH_EN
   // Byte-wise CRC-8 reference (poly 0x07, init 0x00)
   function automatic logic [7:0] crc8_ref(input logic [47:0] a);
      logic [7:0] c;
      logic [7:0] t;
      c = 8'h00;
      for (int i = 0; i < 6; i++) begin
         t = c ^ a[47-8*i -: 8];
         for (int k = 0; k < 8; k++) t = t[7] ? ((t << 1) ^ 8'h07) : (t << 1);
         c = t;
      end
      return c;
   endfunction

   function automatic vec_t fix(input vec_t v);
      vec_t r;
      r = v;
      r.exp_sa_idx = crc8_ref(v.sa);
      r.exp_da_idx = crc8_ref(v.da);
      return r;
   endfunction
`else
   function automatic vec_t fix(input vec_t v);
      return v;
   endfunction
`endif

   task automatic send_byte(input logic [7:0] d, input logic sof);
      i_data  = d;
      i_sof   = sof;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_hdr(input logic [1:0] src, input logic [47:0] da, input logic [47:0] sa);
      i_src_port = src;
      for (int i = 0; i < 6; i++) send_byte(da[47-8*i -: 8], (i == 0));
      for (int i = 0; i < 6; i++) send_byte(sa[47-8*i -: 8], 1'b0);
      i_valid = 1'b0;
      i_sof   = 1'b0;
   endtask

   // Sends one header and checks LOOKUP, WAIT and RESULT cycles; if accept,
   // i_fwd_ready is assumed high and the return to IDLE is checked too
   task automatic run_frame(input vec_t v, input string tag, input bit accept);
      send_hdr(v.src, v.da, v.sa);
      chk({tag, ".lookup_we"}, o_write_enable, v.exp_we);
      if (v.exp_we) begin
         chk({tag, ".mac_sa"}, o_MAC_SA, v.exp_sa_idx);
         chk({tag, ".port_num"}, o_port_num, v.exp_pnum);
      end
      chk({tag, ".mac_da"}, o_MAC_DA, v.exp_da_idx);
      chk({tag, ".ready_lookup"}, o_ready, 1'b0);
      chk({tag, ".valid_lookup"}, fwd_if.o_fwd_valid, 1'b0);
      @(posedge clk); #1;
      chk({tag, ".wait_we"}, o_write_enable, 1'b0);
      chk({tag, ".valid_wait"}, fwd_if.o_fwd_valid, 1'b0);
      @(posedge clk); #1;
      chk({tag, ".valid_n3"}, fwd_if.o_fwd_valid, 1'b1);
      chk({tag, ".flood"}, fwd_if.o_fwd_flood, v.exp_flood);
      chk({tag, ".drop"}, fwd_if.o_fwd_drop, v.exp_drop);
      if (!v.exp_flood && !v.exp_drop) chk({tag, ".port"}, fwd_if.o_fwd_port, v.exp_port);
      chk({tag, ".ready_result"}, o_ready, 1'b0);
      if (accept) begin
         @(posedge clk); #1;
         chk({tag, ".valid_done"}, fwd_if.o_fwd_valid, 1'b0);
         chk({tag, ".ready_done"}, o_ready, 1'b1);
      end
   endtask

   vec_t vecs [7];
   vec_t hv;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // src, DA, SA, we, sa_idx, da_idx, pnum, flood, drop, port
      vecs[0] = '{2'd2, 48'h0000_0000_00AA, 48'h0011_2233_4455, 1'b1, 8'h11, 8'hAA, 2'd2, 1'b0, 1'b0, 2'd0};
      vecs[1] = '{2'd1, 48'h0011_2233_4455, 48'h0000_0000_0001, 1'b1, 8'h01, 8'h11, 2'd1, 1'b0, 1'b0, 2'd2};
      vecs[2] = '{2'd2, 48'h0011_2233_4455, 48'h0000_0000_0002, 1'b1, 8'h02, 8'h11, 2'd2, 1'b0, 1'b1, 2'd0};
      vecs[3] = '{2'd3, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0003, 1'b1, 8'h03, 8'h00, 2'd3, 1'b1, 1'b0, 2'd0};
      vecs[4] = '{2'd1, 48'h0000_0000_0001, 48'h0100_5E00_0001, 1'b0, 8'h00, 8'h01, 2'd0, 1'b0, 1'b1, 2'd0};
      vecs[5] = '{2'd3, 48'h0000_0000_0077, 48'h0000_0000_0077, 1'b1, 8'h77, 8'h77, 2'd3, 1'b0, 1'b0, 2'd0};
      vecs[6] = '{2'd1, 48'h0000_0000_0077, 48'h0000_0000_0009, 1'b1, 8'h09, 8'h77, 2'd1, 1'b0, 1'b0, 2'd3};
      for (int i = 0; i < 7; i++) vecs[i] = fix(vecs[i]);

      rst = 1'b1;
      i_data = 8'h00;
      i_valid = 1'b0;
      i_sof = 1'b0;
      i_src_port = 2'd0;
      fwd_if.i_fwd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.ready", o_ready, 1'b1);
      chk("rst.we", o_write_enable, 1'b0);
      chk("rst.valid", fwd_if.o_fwd_valid, 1'b0);
      chk("rst.flood", fwd_if.o_fwd_flood, 1'b0);
      chk("rst.drop", fwd_if.o_fwd_drop, 1'b0);
      chk("rst.mac_sa", o_MAC_SA, 8'h00);
      chk("rst.mac_da", o_MAC_DA, 8'h00);
      chk("rst.port_num", o_port_num, 2'd0);
      chk("rst.fwd_port", fwd_if.o_fwd_port, 2'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i), 1'b1);

      // Payload bytes in IDLE are discarded, then a header aborted at DA byte 3
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      chk("idle.ready", o_ready, 1'b1);
      chk("idle.we", o_write_enable, 1'b0);
      i_src_port = 2'd1;
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b0);
      send_byte(8'hFF, 1'b0);
      chk("abort.ready", o_ready, 1'b1);
      chk("abort.we", o_write_enable, 1'b0);
      hv = fix('{2'd3, 48'h0011_2233_4455, 48'h0000_0000_000A, 1'b1, 8'h0A, 8'h11, 2'd3, 1'b0, 1'b0, 2'd2});
      run_frame(hv, "abort", 1'b1);

      // Fabric back-pressure for 10 cycles: decision held, upstream stalled
      fwd_if.i_fwd_ready = 1'b0;
      hv = fix('{2'd0, 48'h0000_0000_0077, 48'h0000_0000_000B, 1'b1, 8'h0B, 8'h77, 2'd0, 1'b0, 1'b0, 2'd3});
      run_frame(hv, "bp", 1'b0);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk($sformatf("bp.hold_valid%0d", k), fwd_if.o_fwd_valid, 1'b1);
         chk($sformatf("bp.hold_port%0d", k), fwd_if.o_fwd_port, 2'd3);
         chk($sformatf("bp.hold_fl_dr%0d", k), {fwd_if.o_fwd_flood, fwd_if.o_fwd_drop}, 2'b00);
         chk($sformatf("bp.hold_ready%0d", k), o_ready, 1'b0);
      end
      fwd_if.i_fwd_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp.valid_done", fwd_if.o_fwd_valid, 1'b0);
      chk("bp.ready_done", o_ready, 1'b1);

      // Asynchronous reset while in WAIT: outputs clear immediately
      send_hdr(2'd1, 48'h0000_0000_0001, 48'h0000_0000_000C);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rwait.ready", o_ready, 1'b1);
      chk("rwait.we", o_write_enable, 1'b0);
      chk("rwait.valid", fwd_if.o_fwd_valid, 1'b0);
      chk("rwait.fl_dr", {fwd_if.o_fwd_flood, fwd_if.o_fwd_drop}, 2'b00);
      chk("rwait.mac_sa", o_MAC_SA, 8'h00);
      chk("rwait.mac_da", o_MAC_DA, 8'h00);
      chk("rwait.port_num", o_port_num, 2'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rwait.no_decision", fwd_if.o_fwd_valid, 1'b0);
      end
      hv = fix('{2'd2, 48'h0000_0000_0077, 48'h0000_0000_000D, 1'b1, 8'h0D, 8'h77, 2'd2, 1'b0, 1'b0, 2'd3});
      run_frame(hv, "post_rst", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
